// File: rtl/cpu_bus_sequencer.sv
// 65C02 bus sequencer: phi2 generation, CPU reset hold, address decode and strobes, ACIA clock stretch.
// All outputs registered; address/rwb sampled on the edge entering phi2-high and held until phi2 falls.
module cpu_bus_sequencer #(
  parameter int          PHI_LO     = 2,
  parameter int          PHI_HI     = 2,
  parameter int          ACIA_WAIT  = 4,
  parameter logic [15:0] ACIA_BASE  = 16'h8000,
  parameter int          RES_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic        rwb,
  output logic        phi2,
  output logic        resb,
  output logic        ram_cs,
  output logic        rom_cs,
  output logic        acia_cs,
  output logic        oe_n,
  output logic        we_n,
  output logic        stretch
);

  typedef enum logic [1:0] {LOW, HIGH, STRETCH} state_t;

  localparam logic [7:0] LO_N   = 8'(PHI_LO);
  localparam logic [7:0] HI_N   = 8'(PHI_HI);
  localparam logic [7:0] WAIT_N = 8'(ACIA_WAIT);
  localparam int         RW     = $clog2(RES_CYCLES + 1);
  localparam logic [RW-1:0] RES_LAST = RW'(RES_CYCLES - 1);

  state_t        state_q;
  logic [7:0]    cnt_q;
  logic [RW-1:0] res_cnt_q;
  logic          resb_q, phi2_q, ram_q, rom_q, acia_q, oe_n_q, we_n_q, stretch_q;

  logic ram_d, rom_d, acia_d;
  logic phase_end, enter_high, enter_str, enter_low;

  // ACIA window wins over RAM/ROM so selects stay exclusive for any ACIA_BASE.
  always_comb begin
    acia_d = (address[15:2] == ACIA_BASE[15:2]);
    ram_d  = ~address[15] & ~acia_d;
    rom_d  = (address[15:14] == 2'b11) & ~acia_d;
  end

  always_comb begin
    phase_end = 1'b0;
    case (state_q)
      LOW:     phase_end = (cnt_q >= LO_N);
      HIGH:    phase_end = (cnt_q >= HI_N);
      STRETCH: phase_end = (cnt_q >= WAIT_N);
      default: phase_end = 1'b1;
    endcase
    enter_high = (state_q == LOW) && phase_end;
    enter_str  = (state_q == HIGH) && phase_end && acia_q && (WAIT_N != 8'd0);
    enter_low  = (state_q != LOW) && phase_end && !enter_str;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= LOW;
      cnt_q     <= 8'd0;
      res_cnt_q <= '0;
      resb_q    <= 1'b0;
      phi2_q    <= 1'b0;
      ram_q     <= 1'b0;
      rom_q     <= 1'b0;
      acia_q    <= 1'b0;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      stretch_q <= 1'b0;
    end else begin
      cnt_q <= phase_end ? 8'd1 : cnt_q + 8'd1;

      if (enter_high) begin
        state_q <= HIGH;
        phi2_q  <= 1'b1;
        // No bus activity is exposed while the CPU is still held in reset.
        ram_q   <= resb_q & ram_d;
        rom_q   <= resb_q & rom_d;
        acia_q  <= resb_q & acia_d;
        oe_n_q  <= ~(resb_q & rwb);
        we_n_q  <= ~(resb_q & ~rwb);
      end

      if (enter_str) begin
        state_q   <= STRETCH;
        stretch_q <= 1'b1;
      end

      if (enter_low) begin
        state_q   <= LOW;
        phi2_q    <= 1'b0;
        ram_q     <= 1'b0;
        rom_q     <= 1'b0;
        acia_q    <= 1'b0;
        oe_n_q    <= 1'b1;
        we_n_q    <= 1'b1;
        stretch_q <= 1'b0;
        if (!resb_q) begin
          if (res_cnt_q == RES_LAST) resb_q <= 1'b1;
          else                       res_cnt_q <= res_cnt_q + RW'(1);
        end
      end
    end
  end

  assign phi2    = phi2_q;
  assign resb    = resb_q;
  assign ram_cs  = ram_q;
  assign rom_cs  = rom_q;
  assign acia_cs = acia_q;
  assign oe_n    = oe_n_q;
  assign we_n    = we_n_q;
  assign stretch = stretch_q;

endmodule
